// File: rtl/snoop_pkg.sv
// -----------------------------------------------------------------------------
// snoop_pkg
// Shared definitions for the snoop initiator:
//   - cache line status encoding (ST_I / ST_S / ST_E / ST_M)
//   - snoop initiator FSM state encoding
//   - address split into a 16-bit tag and an 8-bit index
// Optional feature macro used by the files importing this package:
//   SNOOP_ERR_CHK_EN - builds the multi-owner / owner-with-sharer conflict check.
// -----------------------------------------------------------------------------
package snoop_pkg;

    // Per-cache 2-bit status as reported on STATUS_IN
    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_E = 2'b10;
    localparam logic [1:0] ST_M = 2'b11;

    // Address layout: {tag, index}
    localparam int TAG_W      = 16;
    localparam int IDX_W      = 8;
    localparam int ADDR_W_DEF = TAG_W + IDX_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BCAST   = 3'd1,
        S_WAIT    = 3'd2,
        S_INV     = 3'd3,
        S_RESOLVE = 3'd4
    } state_t;

endpackage

// File: rtl/snoop_resolve.sv
// -----------------------------------------------------------------------------
// snoop_resolve
// Combinational reduction of all per-cache snoop status slices.
// Optional feature macro: SNOOP_ERR_CHK_EN (adds the conflict output).
// Ports:
//   status   in  2*NCACHE  cache k on bits [2k+1:2k]
//   any_m    out 1         some cache holds M
//   any_v    out 1         some cache holds a non-I copy
//   owner    out 3         lowest M index, else lowest E, else lowest non-I, else 0
//   conflict out 1         (SNOOP_ERR_CHK_EN only) more than one M/E holder,
//                          or an M/E holder alongside an S holder
// -----------------------------------------------------------------------------
module snoop_resolve
    import snoop_pkg::*;
#(
    parameter int NCACHE = 4
) (
    input  logic [2*NCACHE-1:0] status,
    output logic                any_m,
    output logic                any_v,
    output logic [2:0]          owner
`ifdef SNOOP_ERR_CHK_EN
    ,
    output logic                conflict
`endif
);

    logic       any_e;
    logic [2:0] m_idx;
    logic [2:0] e_idx;
    logic [2:0] v_idx;
    logic [1:0] slice;
`ifdef SNOOP_ERR_CHK_EN
    logic       any_s;
    logic [3:0] n_own;
`endif

    // Scanning from the top index down lets the last hit be the lowest index.
    always_comb begin
        any_m = 1'b0;
        any_e = 1'b0;
        any_v = 1'b0;
        m_idx = 3'd0;
        e_idx = 3'd0;
        v_idx = 3'd0;
        slice = ST_I;
`ifdef SNOOP_ERR_CHK_EN
        any_s = 1'b0;
        n_own = 4'd0;
`endif
        for (int k = NCACHE - 1; k >= 0; k--) begin
            slice = status[2*k +: 2];
            if (slice == ST_M) begin
                any_m = 1'b1;
                m_idx = 3'(k);
            end
            if (slice == ST_E) begin
                any_e = 1'b1;
                e_idx = 3'(k);
            end
            if (slice != ST_I) begin
                any_v = 1'b1;
                v_idx = 3'(k);
            end
`ifdef SNOOP_ERR_CHK_EN
            if (slice == ST_S) begin
                any_s = 1'b1;
            end
            if (slice == ST_M || slice == ST_E) begin
                n_own = n_own + 4'd1;
            end
`endif
        end
        owner = any_m ? m_idx : (any_e ? e_idx : v_idx);
`ifdef SNOOP_ERR_CHK_EN
        conflict = (n_own > 4'd1) || ((n_own != 4'd0) && any_s);
`endif
    end

endmodule

// File: rtl/snoop_initiator.sv
// -----------------------------------------------------------------------------
// snoop_initiator
// Requesting end of the snoop protocol. Takes one coherence request at a time,
// broadcasts it to all caches, resolves their statuses into the state the
// requester installs and, on a write hitting other copies, pulses PINV.
// Optional feature macro: SNOOP_ERR_CHK_EN (sticky protocol-violation flag;
// when undefined err is tied low).
//
// Handshake: a request transfers on a rising SCLK edge where req_valid and
// req_ready are both high; req_addr/req_rw are captured on that edge. req_ready
// is high only in IDLE, so the requester may hold req_valid continuously and
// each request is taken the cycle after the previous resp_valid.
//
// Ports:
//   SCLK, SRST            clock (rising edge), async active-low reset
//   req_valid/ready       request handshake, req_addr / req_rw payload
//   ADDR, RW, snoop       snoop broadcast to the caches
//   STATUS_IN             per-cache status, cache k on bits [2k+1:2k]
//   PINV                  one-cycle invalidate strobe
//   resp_valid            one-cycle result strobe with resp_state/wb/owner
//   err                   sticky conflict flag
//   fsm_state             current FSM state (observation only)
// -----------------------------------------------------------------------------
module snoop_initiator
    import snoop_pkg::*;
#(
    parameter int NCACHE = 4,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                SCLK,
    input  logic                SRST,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_rw,
    output logic [ADDR_W-1:0]   ADDR,
    output logic                snoop,
    output logic                RW,
    input  logic [2*NCACHE-1:0] STATUS_IN,
    output logic                PINV,
    output logic                resp_valid,
    output logic [1:0]          resp_state,
    output logic                resp_wb,
    output logic [2:0]          resp_owner,
    output logic                err,
    output state_t              fsm_state
);

    state_t     state;
    logic       any_m;
    logic       any_v;
    logic [2:0] owner;
`ifdef SNOOP_ERR_CHK_EN
    logic       conflict;
    logic       conflict_q;
`endif

    assign fsm_state = state;

    snoop_resolve #(
        .NCACHE (NCACHE)
    ) u_resolve (
        .status   (STATUS_IN),
        .any_m    (any_m),
        .any_v    (any_v),
        .owner    (owner)
`ifdef SNOOP_ERR_CHK_EN
        ,
        .conflict (conflict)
`endif
    );

    // The resolved result is captured at the end of WAIT, which is the
    // registered snapshot of STATUS_IN; resp_* then hold until the next WAIT.
    always_ff @(posedge SCLK or negedge SRST) begin
        if (!SRST) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            ADDR       <= '0;
            RW         <= 1'b0;
            snoop      <= 1'b0;
            PINV       <= 1'b0;
            resp_valid <= 1'b0;
            resp_state <= ST_I;
            resp_wb    <= 1'b0;
            resp_owner <= 3'd0;
        end else begin
            snoop      <= 1'b0;
            PINV       <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        ADDR      <= req_addr;
                        RW        <= req_rw;
                        req_ready <= 1'b0;
                        snoop     <= 1'b1;
                        state     <= S_BCAST;
                    end
                end
                S_BCAST: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    resp_state <= RW ? ST_M : (any_v ? ST_S : ST_E);
                    resp_wb    <= any_m;
                    resp_owner <= owner;
                    if (RW && any_v) begin
                        PINV  <= 1'b1;
                        state <= S_INV;
                    end else begin
                        resp_valid <= 1'b1;
                        state      <= S_RESOLVE;
                    end
                end
                S_INV: begin
                    resp_valid <= 1'b1;
                    state      <= S_RESOLVE;
                end
                S_RESOLVE: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SNOOP_ERR_CHK_EN
    // err rises on the edge entering RESOLVE so it is visible in the
    // resp_valid cycle; the INV path uses the conflict captured in WAIT.
    always_ff @(posedge SCLK or negedge SRST) begin
        if (!SRST) begin
            err        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            if (state == S_WAIT) begin
                conflict_q <= conflict;
                if (!(RW && any_v) && conflict) begin
                    err <= 1'b1;
                end
            end
            if (state == S_INV && conflict_q) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_snoop_initiator.sv
module tb_snoop_initiator;
    import snoop_pkg::*;

    localparam int NC = 4;
    localparam int AW = 24;

    logic            SCLK;
    logic            SRST;
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_addr;
    logic            req_rw;
    logic [AW-1:0]   ADDR;
    logic            snoop;
    logic            RW;
    logic [2*NC-1:0] STATUS_IN;
    logic            PINV;
    logic            resp_valid;
    logic [1:0]      resp_state;
    logic            resp_wb;
    logic [2:0]      resp_owner;
    logic            err;
    state_t          fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    // {err, state[1:0], wb, owner[2:0]}
    logic [6:0] exp_q[$];
    logic [6:0] exp_item;
    logic       exp_err = 1'b0;

    snoop_initiator #(.NCACHE(NC), .ADDR_W(AW)) dut (
        .SCLK       (SCLK),
        .SRST       (SRST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_rw     (req_rw),
        .ADDR       (ADDR),
        .snoop      (snoop),
        .RW         (RW),
        .STATUS_IN  (STATUS_IN),
        .PINV       (PINV),
        .resp_valid (resp_valid),
        .resp_state (resp_state),
        .resp_wb    (resp_wb),
        .resp_owner (resp_owner),
        .err        (err),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock ----------------
    initial begin
        SCLK = 1'b0;
        forever #5 SCLK = ~SCLK;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference resolution: returns {inv, conflict, state[1:0], wb, owner[2:0]}
    function automatic logic [7:0] model(input logic [2*NC-1:0] st, input logic rw);
        int         n_me;
        bit         has_s;
        bit         has_v;
        int         om;
        int         oe;
        int         ov;
        logic [1:0] s;
        logic [1:0] nst;
        logic [2:0] own;
        n_me = 0; has_s = 0; has_v = 0; om = -1; oe = -1; ov = -1;
        for (int k = 0; k < NC; k++) begin
            s = st[2*k +: 2];
            if (s == 2'b11) begin n_me++; if (om < 0) om = k; end
            if (s == 2'b10) begin n_me++; if (oe < 0) oe = k; end
            if (s == 2'b01) has_s = 1;
            if (s != 2'b00) begin has_v = 1; if (ov < 0) ov = k; end
        end
        if (om >= 0)      own = 3'(om);
        else if (oe >= 0) own = 3'(oe);
        else if (ov >= 0) own = 3'(ov);
        else              own = 3'd0;
        nst = rw ? 2'b11 : (has_v ? 2'b01 : 2'b10);
        return {rw && has_v, (n_me > 1) || (n_me > 0 && has_s), nst, om >= 0, own};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge SCLK) begin
        if (SRST && resp_valid) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
                exp_item = exp_q.pop_front();
                check("resp_err",   32'(err),        32'(exp_item[6]));
                check("resp_state", 32'(resp_state), 32'(exp_item[5:4]));
                check("resp_wb",    32'(resp_wb),    32'(exp_item[3]));
                check("resp_owner", 32'(resp_owner), 32'(exp_item[2:0]));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_req(input logic [AW-1:0] addr, input logic rw,
                           input logic [2*NC-1:0] st, input bit chain, output int waited);
        logic [7:0] m;
        m = model(st, rw);
        @(negedge SCLK);
        req_valid = 1'b1;
        req_addr  = addr;
        req_rw    = rw;
        STATUS_IN = st;
        waited    = 0;
        while (!req_ready && waited < 20) begin
            @(negedge SCLK);
            waited++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge SCLK);
`ifdef SNOOP_ERR_CHK_EN
        exp_err = exp_err | m[6];
`endif
        exp_q.push_back({exp_err, m[5:0]});
        @(negedge SCLK);  // cycle 1
        check("bcast_snoop", 32'(snoop), 32'd1);
        check("bcast_addr",  32'(ADDR),  32'(addr));
        check("bcast_rw",    32'(RW),    32'(rw));
        check("bcast_ready", 32'(req_ready), 32'd0);
        if (!chain) req_valid = 1'b0;
        @(negedge SCLK);  // cycle 2
        check("wait_snoop", 32'(snoop), 32'd0);
        check("wait_addr",  32'(ADDR),  32'(addr));
        check("wait_pinv",  32'(PINV),  32'd0);
        @(negedge SCLK);  // cycle 3
        if (m[7]) begin
            check("inv_pinv", 32'(PINV),       32'd1);
            check("inv_addr", 32'(ADDR),       32'(addr));
            check("inv_resp", 32'(resp_valid), 32'd0);
            @(negedge SCLK);  // cycle 4
        end
        check("resolve_valid", 32'(resp_valid), 32'd1);
        check("resolve_pinv",  32'(PINV),       32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready),  32'd1);
        check({tag, "_addr"},  32'(ADDR),       32'd0);
        check({tag, "_rw"},    32'(RW),         32'd0);
        check({tag, "_snoop"}, 32'(snoop),      32'd0);
        check({tag, "_pinv"},  32'(PINV),       32'd0);
        check({tag, "_rv"},    32'(resp_valid), 32'd0);
        check({tag, "_rs"},    32'(resp_state), 32'd0);
        check({tag, "_wb"},    32'(resp_wb),    32'd0);
        check({tag, "_own"},   32'(resp_owner), 32'd0);
        check({tag, "_err"},   32'(err),        32'd0);
        check({tag, "_fsm"},   32'(fsm_state),  32'(S_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        SRST      = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_rw    = 1'b0;
        STATUS_IN = '0;
        repeat (3) @(negedge SCLK);
        check_reset_outputs("reset");
        SRST = 1'b1;

        // Read, all caches I -> E
        run_req(24'h123456, 1'b0, 8'h00, 1'b0, w);
        // Read, cache 2 = S -> S, owner 2
        run_req(24'hABCDEF, 1'b0, 8'h10, 1'b0, w);
        // Write, cache 1 = M -> INV, M, wb, owner 1
        run_req(24'h00FF01, 1'b1, 8'h0C, 1'b0, w);
        // Write, all I -> no INV
        run_req(24'h55AA55, 1'b1, 8'h00, 1'b0, w);
        // Read, cache 0 = E -> S, owner 0
        run_req(24'h010203, 1'b0, 8'h02, 1'b0, w);
        // Read, caches 1 and 3 = M -> lowest index 1, wb
        run_req(24'hFEDCBA, 1'b0, 8'hCC, 1'b0, w);
        // Cache 0 = M, cache 3 = S; err sticky when the check is built
        run_req(24'h777777, 1'b0, 8'h43, 1'b0, w);
        repeat (3) @(negedge SCLK);
        check("err_sticky", 32'(err), 32'(exp_err));

        // Back-to-back with req_valid held
        run_req(24'h100001, 1'b0, 8'h01, 1'b1, w);
        run_req(24'h200002, 1'b1, 8'h04, 1'b0, w);
        check("b2b_gap", 32'(w), 32'd0);

        // Random traffic
        for (int i = 0; i < 12; i++) begin
            run_req(AW'($urandom), 1'($urandom_range(0, 1)),
                    (2*NC)'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), w);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge SCLK);
        check("err_before_rst", 32'(err), 32'(exp_err));

        // Reset asserted in WAIT aborts the request
        @(negedge SCLK);
        req_valid = 1'b1;
        req_addr  = 24'hC0FFEE;
        req_rw    = 1'b1;
        STATUS_IN = 8'hFF;
        @(posedge SCLK);
        @(negedge SCLK);
        check("abort_bcast", 32'(snoop), 32'd1);
        req_valid = 1'b0;
        @(negedge SCLK);
        check("abort_in_wait", 32'(fsm_state), 32'(S_WAIT));
        SRST = 1'b0;
        exp_err = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge SCLK);
        SRST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge SCLK);
            check("abort_no_resp", 32'(resp_valid), 32'd0);
            check("abort_no_pinv", 32'(PINV), 32'd0);
        end

        // Normal operation resumes after the abort
        run_req(24'h123456, 1'b0, 8'h80, 1'b0, w);
        repeat (2) @(negedge SCLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
